packet_slot_scheduler: RTL and testbench

- Periodic packet scheduler: each PERIOD-cycle slot (10 Hz at 100 MHz by default) carries at most one packet from one of NUM_REQ requesters.
- Requesters are served round-robin.
- Each packet goes out as a byte sequence to a downstream byte transmitter over a valid/ready handshake.
- Sits between the command sources and the serial/IR transmit path, replacing free-running SEND_PACKET use.

---
 rtl/pkt_sched_pkg.sv | 57 +++++
 rtl/packet_slot_scheduler_tick.sv | 43 ++++
 rtl/packet_slot_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_packet_slot_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_sched_pkg.sv
// -----------------------------------------------------------------------------
// pkt_sched_pkg
// Shared types and helpers for the packet slot scheduler.
//   state_t          : scheduler FSM states
//   DEFAULT_HEADER   : default first byte of every packet
//   PKT_LEN_*        : packet length in bytes without / with checksum byte
//   rr_next_idx()    : round-robin winner search starting after last grant
//   pkt_checksum()   : XOR checksum over header, index byte and payload
// -----------------------------------------------------------------------------
package pkt_sched_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        ID   = 3'd2,
        PAY  = 3'd3,
        CHK  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;
    localparam int unsigned PKT_LEN_NO_CHK = 32'd3;
    localparam int unsigned PKT_LEN_CHK    = 32'd4;
    localparam int unsigned MAX_REQ        = 32'd8;

    // First asserted request scanning upward from last_v+1, modulo num_req.
    // Returns last_v unchanged when no request is pending.
    function automatic logic [2:0] rr_next_idx(
        input logic [MAX_REQ-1:0] req_v,
        input logic [2:0]         last_v,
        input int unsigned        num_req
    );
        logic [2:0]  sel_v;
        logic        found_v;
        int unsigned cand_v;
        sel_v   = last_v;
        found_v = 1'b0;
        for (int unsigned k = 32'd1; k <= MAX_REQ; k++) begin
            cand_v = (32'(last_v) + k) % num_req;
            if ((k <= num_req) && !found_v && req_v[cand_v[2:0]]) begin
                sel_v   = cand_v[2:0];
                found_v = 1'b1;
            end
        end
        return sel_v;
    endfunction

    // Checksum byte carried at the end of a packet when enabled.
    function automatic logic [7:0] pkt_checksum(
        input logic [7:0] hdr_v,
        input logic [2:0] idx_v,
        input logic [7:0] pay_v
    );
        return hdr_v ^ {5'b00000, idx_v} ^ pay_v;
    endfunction

endpackage

// File: rtl/packet_slot_scheduler_tick.sv
// -----------------------------------------------------------------------------
// slot_tick_gen
// Free-running slot counter 0..PERIOD-1 with a registered one-cycle tick.
// The tick is high in the cycle after the counter held PERIOD-1, so the first
// tick appears PERIOD+1 cycles after reset release and repeats every PERIOD.
// Ports:
//   CLK   in  system clock
//   RESET in  asynchronous active-high reset
//   TICK  out one-cycle slot tick
// -----------------------------------------------------------------------------
module slot_tick_gen
    import pkt_sched_pkg::*;
#(
    parameter int PERIOD    = 10000000,
    parameter int CNT_WIDTH = 32
) (
    input  logic CLK,
    input  logic RESET,
    output logic TICK
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(PERIOD - 1);

    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 tick_r;

    // Slot counter with wrap and registered tick.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r == LAST_CNT) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNT_WIDTH'(1);
            tick_r <= 1'b0;
        end
    end

    assign TICK = tick_r;

endmodule

// File: rtl/packet_slot_scheduler.sv
// -----------------------------------------------------------------------------
// packet_slot_scheduler
// Sends at most one packet per PERIOD-cycle slot, choosing among NUM_REQ
// requesters round-robin. Packet = HEADER, {5'b0,index}, payload
// [, checksum when PKT_CHECKSUM_EN is defined], over a valid/ready byte link.
// Optional feature macro: PKT_CHECKSUM_EN (adds the CHK byte).
// Ports:
//   CLK       in  system clock
//   RESET     in  asynchronous active-high reset
//   REQ       in  per-requester pending flags (sampled at IDLE tick only)
//   REQ_DATA  in  payload byte per requester, byte i at [8i+7:8i]
//   GRANT     out one-cycle pulse on the served requester at packet end
//   TX_DATA   out byte to transmitter (registered)
//   TX_VALID  out TX_DATA valid (registered)
//   TX_READY  in  transmitter accepts on TX_VALID && TX_READY
//   BUSY      out high whenever the FSM is not IDLE
//   OVERRUN   out one-cycle pulse when a tick is dropped while busy
// -----------------------------------------------------------------------------
module packet_slot_scheduler
    import pkt_sched_pkg::*;
#(
    parameter int         PERIOD    = 10000000,
    parameter int         CNT_WIDTH = 32,
    parameter int         NUM_REQ   = 4,
    parameter logic [7:0] HEADER    = DEFAULT_HEADER
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [NUM_REQ-1:0]   REQ,
    input  logic [8*NUM_REQ-1:0] REQ_DATA,
    output logic [NUM_REQ-1:0]   GRANT,
    output logic [7:0]           TX_DATA,
    output logic                 TX_VALID,
    input  logic                 TX_READY,
    output logic                 BUSY,
    output logic                 OVERRUN
);

    logic                 tick_s;
    state_t               state_r;
    state_t               state_nx_s;
    logic                 start_s;
    logic                 accept_s;
    logic [MAX_REQ-1:0]   req_pad_s;
    logic [2:0]           win_s;
    logic [7:0]           win_pay_s;
    logic [2:0]           idx_r;
    logic [7:0]           pay_r;
    logic [2:0]           last_grant_r;
    logic [7:0]           tx_data_nx_s;
    logic                 tx_valid_nx_s;
    logic [NUM_REQ-1:0]   grant_nx_s;
    logic [7:0]           tx_data_r;
    logic                 tx_valid_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic                 busy_r;
    logic                 overrun_r;

    slot_tick_gen #(
        .PERIOD    (PERIOD),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_tick (
        .CLK   (CLK),
        .RESET (RESET),
        .TICK  (tick_s)
    );

    // Round-robin winner and its payload byte.
    always_comb begin
        req_pad_s              = '0;
        req_pad_s[NUM_REQ-1:0] = REQ;
        win_s                  = rr_next_idx(req_pad_s, last_grant_r, NUM_REQ);
        win_pay_s              = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_s == 3'(i)) begin
                win_pay_s = REQ_DATA[8*i +: 8];
            end else begin
                win_pay_s = win_pay_s;
            end
        end
    end

    // Next-state logic; byte states advance only on acceptance.
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        accept_s   = tx_valid_r && TX_READY;
        case (state_r)
            IDLE: begin
                if (tick_s && (REQ != '0)) begin
                    state_nx_s = HDR;
                    start_s    = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            HDR: begin
                if (accept_s) begin
                    state_nx_s = ID;
                end else begin
                    state_nx_s = HDR;
                end
            end
            ID: begin
                if (accept_s) begin
                    state_nx_s = PAY;
                end else begin
                    state_nx_s = ID;
                end
            end
            PAY: begin
                if (accept_s) begin
`ifdef PKT_CHECKSUM_EN
                    state_nx_s = CHK;
`else
                    state_nx_s = DONE;
`endif
                end else begin
                    state_nx_s = PAY;
                end
            end
`ifdef PKT_CHECKSUM_EN
            CHK: begin
                if (accept_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = CHK;
                end
            end
`endif
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Output values for the state being entered, so outputs can be registered
    // and stay aligned with state_r (data held stable while stalled).
    always_comb begin
        tx_data_nx_s  = 8'h00;
        tx_valid_nx_s = 1'b0;
        case (state_nx_s)
            HDR: begin
                tx_data_nx_s  = HEADER;
                tx_valid_nx_s = 1'b1;
            end
            ID: begin
                tx_data_nx_s  = {5'b00000, idx_r};
                tx_valid_nx_s = 1'b1;
            end
            PAY: begin
                tx_data_nx_s  = pay_r;
                tx_valid_nx_s = 1'b1;
            end
`ifdef PKT_CHECKSUM_EN
            CHK: begin
                tx_data_nx_s  = pkt_checksum(HEADER, idx_r, pay_r);
                tx_valid_nx_s = 1'b1;
            end
`endif
            default: begin
                tx_data_nx_s  = 8'h00;
                tx_valid_nx_s = 1'b0;
            end
        endcase
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_nx_s[i] = (state_nx_s == DONE) && (idx_r == 3'(i));
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r    <= IDLE;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            grant_r    <= '0;
            busy_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            tx_data_r  <= tx_data_nx_s;
            tx_valid_r <= tx_valid_nx_s;
            grant_r    <= grant_nx_s;
            busy_r     <= (state_nx_s != IDLE);
            overrun_r  <= tick_s && (state_r != IDLE);
        end
    end

    // Packet context latched at the start tick; last grant updated in DONE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            idx_r        <= 3'd0;
            pay_r        <= 8'h00;
            last_grant_r <= 3'(NUM_REQ - 1);
        end else begin
            if (start_s) begin
                idx_r <= win_s;
                pay_r <= win_pay_s;
            end
            if (state_r == DONE) begin
                last_grant_r <= idx_r;
            end
        end
    end

    assign TX_DATA  = tx_data_r;
    assign TX_VALID = tx_valid_r;
    assign GRANT    = grant_r;
    assign BUSY     = busy_r;
    assign OVERRUN  = overrun_r;

endmodule

// File: tb/tb_packet_slot_scheduler.sv
// -----------------------------------------------------------------------------
// tb_packet_slot_scheduler
// Scoreboard bench: stimulus pushes expected bytes/grants into queues; a
// negedge monitor pops and compares on every accepted byte and every GRANT.
// -----------------------------------------------------------------------------
module tb_packet_slot_scheduler;

    localparam int PERIOD  = 16;
    localparam int NUM_REQ = 4;
`ifdef PKT_CHECKSUM_EN
    localparam int NBYTES = 4;
`else
    localparam int NBYTES = 3;
`endif

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic [NUM_REQ-1:0]   REQ;
    logic [8*NUM_REQ-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]   GRANT;
    logic [7:0]           TX_DATA;
    logic                 TX_VALID;
    logic                 TX_READY;
    logic                 BUSY;
    logic                 OVERRUN;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ovr_cnt = 0;

    logic [7:0] exp_bytes[$];
    logic [3:0] exp_grants[$];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    packet_slot_scheduler #(
        .PERIOD    (PERIOD),
        .CNT_WIDTH (8),
        .NUM_REQ   (NUM_REQ),
        .HEADER    (8'hA5)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .REQ      (REQ),
        .REQ_DATA (REQ_DATA),
        .GRANT    (GRANT),
        .TX_DATA  (TX_DATA),
        .TX_VALID (TX_VALID),
        .TX_READY (TX_READY),
        .BUSY     (BUSY),
        .OVERRUN  (OVERRUN)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // Monitor: compares accepted bytes and grants against the scoreboard.
    always @(negedge CLK) begin
        logic [7:0] eb;
        logic [3:0] eg;
        if (RESET) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                tests++;
                if (!(TX_VALID && TX_DATA == prev_data)) begin
                    fails++;
                    $display("FAIL hold_stable: got valid=%0b data=%02h expected valid=1 data=%02h",
                             TX_VALID, TX_DATA, prev_data);
                end
            end
            if (TX_VALID && TX_READY) begin
                tests++;
                if (exp_bytes.size() == 0) begin
                    fails++;
                    $display("FAIL tx_byte: got %02h expected no byte", TX_DATA);
                end else begin
                    eb = exp_bytes.pop_front();
                    if (TX_DATA !== eb) begin
                        fails++;
                        $display("FAIL tx_byte: got %02h expected %02h", TX_DATA, eb);
                    end
                end
            end
            if (GRANT != '0) begin
                tests++;
                if (exp_grants.size() == 0) begin
                    fails++;
                    $display("FAIL grant: got %04b expected no grant", GRANT);
                end else begin
                    eg = exp_grants.pop_front();
                    if (GRANT !== eg) begin
                        fails++;
                        $display("FAIL grant: got %04b expected %04b", GRANT, eg);
                    end
                end
            end
            if (OVERRUN) ovr_cnt++;
            prev_stall = TX_VALID && !TX_READY;
            prev_data  = TX_DATA;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_pkt(input logic [2:0] idx, input logic [7:0] pay);
        logic [3:0] g;
        g = 4'b0001 << idx;
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back({5'b00000, idx});
        exp_bytes.push_back(pay);
`ifdef PKT_CHECKSUM_EN
        exp_bytes.push_back(8'hA5 ^ {5'b00000, idx} ^ pay);
`endif
        exp_grants.push_back(g);
    endtask

    // Edges until TX_VALID is seen; c = cycle stamp, -1 on timeout.
    task automatic wait_valid(input string name, output int edges, output int c);
        c = -1;
        edges = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge CLK);
            #1;
            if (TX_VALID) begin
                c = cyc;
                edges = n;
                break;
            end
        end
        if (c < 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got timeout expected TX_VALID", name);
        end
    endtask

    task automatic wait_grant(input string name, output int c);
        c = -1;
        for (int n = 0; n < 200; n++) begin
            @(posedge CLK);
            #1;
            if (GRANT != '0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got timeout expected GRANT", name);
        end
    endtask

    initial begin
        int n, vc, gc, bad, ovr0, ng;
        RESET    = 1'b1;
        REQ      = '0;
        REQ_DATA = '0;
        TX_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_tx_valid", TX_VALID, 0);
        check("rst_tx_data", TX_DATA, 8'h00);
        check("rst_grant", GRANT, 4'b0000);
        check("rst_busy", BUSY, 0);
        check("rst_overrun", OVERRUN, 0);

        // Single request from requester 2, hand-computed bytes.
        REQ      = 4'b0100;
        REQ_DATA = 32'h44_3C_22_11;
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'h02);
        exp_bytes.push_back(8'h3C);
`ifdef PKT_CHECKSUM_EN
        exp_bytes.push_back(8'h9B);
`endif
        exp_grants.push_back(4'b0100);
        @(negedge CLK);
        RESET = 1'b0;
        wait_valid("single_valid", n, vc);
        check("first_tick_latency", n, 17);
        check("single_busy", BUSY, 1);
        wait_grant("single_grant", gc);
        REQ = '0;
        check("single_pkt_len", gc - vc, NBYTES);
        @(posedge CLK);
        #1;
        check("grant_one_cycle", GRANT, 4'b0000);
        check("busy_after_done", BUSY, 0);

        // Empty slots: nothing may happen.
        bad = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (BUSY || TX_VALID || OVERRUN) bad++;
        end
        check("empty_slot", bad, 0);

        // Round-robin from reset with all requesters pending.
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        REQ      = 4'b1111;
        REQ_DATA = 32'hD3_C2_B1_A0;
        push_pkt(3'd0, 8'hA0);
        push_pkt(3'd1, 8'hB1);
        push_pkt(3'd2, 8'hC2);
        push_pkt(3'd3, 8'hD3);
        push_pkt(3'd0, 8'hA0);
        ovr0 = ovr_cnt;
        @(negedge CLK);
        RESET = 1'b0;
        ng = 0;
        for (int k = 0; k < 200 && ng < 5; k++) begin
            @(posedge CLK);
            #1;
            if (GRANT != '0) ng++;
        end
        REQ = '0;
        check("rr_grant_count", ng, 5);
        check("rr_overrun", ovr_cnt - ovr0, 0);

        // Backpressure: 3 stall cycles while the ID byte is presented.
        REQ      = 4'b0100;
        REQ_DATA = 32'h00_77_00_00;
        push_pkt(3'd2, 8'h77);
        wait_valid("bp_valid", n, vc);
        check("bp_hdr", TX_DATA, 8'hA5);
        @(posedge CLK);
        #1;
        check("bp_id", TX_DATA, 8'h02);
        TX_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("bp_id_held", TX_DATA, 8'h02);
        check("bp_valid_held", TX_VALID, 1);
        TX_READY = 1'b1;
        wait_grant("bp_grant", gc);
        REQ = '0;
        check("bp_pkt_len", gc - vc, NBYTES + 3);

        // Overrun: header stalled 40 cycles spans two ticks.
        TX_READY = 1'b0;
        REQ      = 4'b1000;
        REQ_DATA = 32'hE1_00_00_00;
        push_pkt(3'd3, 8'hE1);
        ovr0 = ovr_cnt;
        wait_valid("ovr_valid", n, vc);
        repeat (40) @(posedge CLK);
        #1;
        check("ovr_hdr_held", TX_DATA, 8'hA5);
        check("ovr_valid_held", TX_VALID, 1);
        TX_READY = 1'b1;
        wait_grant("ovr_grant", gc);
        REQ = '0;
        check("ovr_pkt_len", gc - vc, 40 + NBYTES);
        @(negedge CLK);
        check("overrun_pulses", ovr_cnt - ovr0, 2);

        // Reset during PAY: abandon packet, then restart tick timing.
        REQ      = 4'b0001;
        REQ_DATA = 32'h00_00_00_5E;
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'h00);
        wait_valid("rst_mid_valid", n, vc);
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        check("rst_mid_pay", TX_DATA, 8'h5E);
        RESET = 1'b1;
        #1;
        check("rst_mid_valid0", TX_VALID, 0);
        check("rst_mid_busy0", BUSY, 0);
        check("rst_mid_grant0", GRANT, 4'b0000);
        REQ_DATA = 32'h00_00_00_69;
        push_pkt(3'd0, 8'h69);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        wait_valid("rst_rel_valid", n, vc);
        check("tick_after_reset", n, 17);
        wait_grant("rst_rel_grant", gc);
        REQ = '0;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        #1;
        check("bytes_left", exp_bytes.size(), 0);
        check("grants_left", exp_grants.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
